// File: rtl/uart_arbiter.sv
// uart_arbiter: shares one uart_tx between N_REQ byte-stream requesters,
// round-robin at message granularity with an idle-timeout grant revoke.
module uart_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 4800
) (
    input  logic               clk48,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_v,
    input  logic [8*N_REQ-1:0] req_d,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         uart_d,
    output logic               uart_d_v,
    input  logic               uart_busy,
    input  logic               uart_done
);

    localparam int IW = (N_REQ > 2) ? 2 : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

    state_t           state, state_n;
    logic [IW-1:0]    owner, owner_n;
    logic [IW-1:0]    last_grant, last_grant_n;
    logic [IW-1:0]    pick;
    logic             found;
    logic             last_flag, last_flag_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [N_REQ-1:0] grant_n, req_ack_n;
    logic [7:0]       uart_d_n;
    logic             uart_d_v_n;
    logic             own_v, own_last;
    logic [7:0]       own_d;

    assign own_v    = req_v[owner];
    assign own_last = req_last[owner];
    assign own_d    = req_d[8*owner +: 8];

    // Search starts just after the previous owner, wrapping modulo N_REQ.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req_v[(int'(last_grant) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = IW'((int'(last_grant) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        last_flag_n  = last_flag;
        cnt_n        = cnt;
        grant_n      = grant;
        uart_d_n     = uart_d;
        uart_d_v_n   = 1'b0;
        req_ack_n    = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_n = pick;
                    grant_n = N_REQ'(1) << pick;
                    cnt_n   = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (own_v) begin
                    if (!uart_busy) begin
                        uart_d_n    = own_d;
                        last_flag_n = own_last;
                        uart_d_v_n  = 1'b1;
                        req_ack_n   = grant;
                        state_n     = WAIT;
                    end
                end else if (cnt == TO_LAST) begin
                    grant_n      = '0;
                    last_grant_n = owner;
                    state_n      = IDLE;
                end else if (cnt < TO_LAST) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (uart_done) begin
                    if (last_flag) begin
                        grant_n      = '0;
                        last_grant_n = owner;
                        state_n      = IDLE;
                    end else begin
                        cnt_n   = '0;
                        state_n = LOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= LAST_IDX;
            last_flag  <= 1'b0;
            cnt        <= '0;
            grant      <= '0;
            req_ack    <= '0;
            uart_d     <= 8'h00;
            uart_d_v   <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            last_flag  <= last_flag_n;
            cnt        <= cnt_n;
            grant      <= grant_n;
            req_ack    <= req_ack_n;
            uart_d     <= uart_d_n;
            uart_d_v   <= uart_d_v_n;
        end
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// tb_uart_arbiter: directed and randomized checks of uart_arbiter against
// a queue-based round-robin message model and a behavioural uart_tx.
module tb_uart_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic           clk48 = 1'b0;
    logic           rst;
    logic [N-1:0]   req_v;
    logic [8*N-1:0] req_d;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic [7:0]     uart_d;
    logic           uart_d_v;
    logic           uart_busy;
    logic           uart_done;

    always #10 clk48 = ~clk48;

    uart_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk48     (clk48),
        .rst       (rst),
        .req_v     (req_v),
        .req_d     (req_d),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .grant     (grant),
        .uart_d    (uart_d),
        .uart_d_v  (uart_d_v),
        .uart_busy (uart_busy),
        .uart_done (uart_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [8:0] rq [N][$];
    int         gap [N];
    int         gmax       = 0;
    bit         rnd_dur    = 0;
    bit         force_busy = 0;
    int         ub_cnt     = 0;
    bit         outstanding = 0;
    bit         prev_busy  = 0;

    logic [7:0] exp_b [$];
    int         exp_o [$];
    int         dv_hist [$];
    int         done_hist [$];
    int         fall_hist [$];
    int         dv_cnt;
    int         ack_cnt [N];
    int         rise_n;
    int         rise_cyc;
    logic [N-1:0] rise_val;
    logic [N-1:0] prev_grant = '0;
    int         m_last = N - 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            req_v[i]          = (rq[i].size() > 0) && (gap[i] == 0);
            req_d[8*i +: 8]   = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            req_last[i]       = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
        end
    endtask

    task automatic push(int i, logic [7:0] b, bit last);
        rq[i].push_back({last, b});
    endtask

    task automatic expect_b(logic [7:0] b, int o);
        exp_b.push_back(b);
        exp_o.push_back(o);
    endtask

    task automatic clear_stats();
        dv_hist.delete();
        done_hist.delete();
        fall_hist.delete();
        dv_cnt   = 0;
        rise_n   = 0;
        rise_cyc = -1;
        rise_val = '0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    endtask

    // Round-robin over whole messages, everyone pending from the start.
    task automatic sched();
        logic [8:0] cp [N][$];
        logic [8:0] e;
        int i;
        bit any;
        for (int j = 0; j < N; j++) cp[j] = rq[j];
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (!any && cp[i].size() > 0) begin
                    any    = 1'b1;
                    m_last = i;
                    do begin
                        e = cp[i].pop_front();
                        expect_b(e[7:0], i);
                    end while (!e[8] && cp[i].size() > 0);
                end
            end
        end
    endtask

    task automatic tick();
        logic [7:0] b;
        int o;
        bit done_now;
        @(posedge clk48);
        #1;
        cyc++;
        chk("grant_onehot", 32'($countones(grant) <= 1), 1);
        if (uart_d_v) begin
            chk("dv_not_busy", prev_busy, 0);
            chk("dv_single", outstanding, 0);
            chk("ack_with_dv", req_ack, grant);
            if (dv_hist.size() > 0 && dv_hist[$] > rise_cyc
                && done_hist.size() > 0)
                chk("dv_after_done", 32'((cyc - done_hist[$]) >= 2), 1);
            chk("dv_expected", 32'(exp_b.size() != 0), 1);
            if (exp_b.size() != 0) begin
                b = exp_b.pop_front();
                o = exp_o.pop_front();
                chk("dv_byte", uart_d, b);
                chk("dv_owner", grant, 32'(1) << o);
            end
            dv_cnt++;
            dv_hist.push_back(cyc);
            outstanding = 1'b1;
        end else if (req_ack != '0) begin
            chk("ack_without_dv", req_ack, 0);
        end
        if (grant != prev_grant) begin
            if (grant == '0) begin
                fall_hist.push_back(cyc);
            end else begin
                rise_n++;
                rise_cyc = cyc;
                rise_val = grant;
            end
        end
        prev_grant = grant;
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                ack_cnt[i]++;
                if (rq[i].size() > 0) void'(rq[i].pop_front());
                gap[i] = int'($urandom_range(gmax, 0));
            end else if (gap[i] > 0) begin
                gap[i]--;
            end
        end
        done_now = 1'b0;
        if (uart_d_v) begin
            ub_cnt = rnd_dur ? int'($urandom_range(14, 8)) : 10;
        end else if (ub_cnt > 0) begin
            ub_cnt--;
            if (ub_cnt == 0) done_now = 1'b1;
        end
        if (done_now) begin
            outstanding = 1'b0;
            done_hist.push_back(cyc);
        end
        uart_busy = (ub_cnt > 0) || force_busy;
        uart_done = done_now;
        prev_busy = uart_busy;
        drive_req();
    endtask

    function automatic bit all_idle();
        bit r;
        r = (grant == '0) && (ub_cnt == 0) && !uart_done;
        for (int i = 0; i < N; i++)
            if (rq[i].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic run_idle(int bound);
        int n;
        n = 0;
        while (!all_idle() && n < bound) begin
            tick();
            n++;
        end
        chk("run_bounded", 32'(n < bound), 1);
        tick();
        tick();
        chk("exp_drained", exp_b.size(), 0);
    endtask

    task automatic wait_ack(int i, int n, int bound);
        int k;
        k = 0;
        while (ack_cnt[i] < n && k < bound) begin
            tick();
            k++;
        end
        chk("wait_ack", 32'(ack_cnt[i] >= n), 1);
    endtask

    initial begin
        int r;
        int nm;
        int len;
        rst       = 1'b1;
        uart_busy = 1'b0;
        uart_done = 1'b0;
        for (int i = 0; i < N; i++) gap[i] = 0;
        drive_req();
        clear_stats();
        repeat (3) tick();
        chk("rst_grant", grant, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_uart_d", uart_d, 8'h00);
        chk("rst_uart_d_v", uart_d_v, 0);
        rst = 1'b0;
        tick();

        // Contention straight after reset, then a second round.
        for (int round = 0; round < 2; round++) begin
            clear_stats();
            push(0, 8'hA0, 0);
            push(0, 8'hA1, 1);
            push(1, 8'hB0, 0);
            push(1, 8'hB1, 1);
            sched();
            drive_req();
            run_idle(500);
            chk("cont_acks0", ack_cnt[0], 2);
            chk("cont_acks1", ack_cnt[1], 2);
        end

        // Single message with latency checks.
        clear_stats();
        push(0, 8'h41, 0);
        push(0, 8'h42, 0);
        push(0, 8'h0A, 1);
        expect_b(8'h41, 0);
        expect_b(8'h42, 0);
        expect_b(8'h0A, 0);
        m_last = 0;
        drive_req();
        tick();
        chk("lat_grant", grant, 2'b01);
        chk("lat_dv_early", uart_d_v, 0);
        tick();
        chk("lat_dv", uart_d_v, 1);
        run_idle(500);
        chk("single_dv_cnt", dv_cnt, 3);
        chk("single_ack_cnt", ack_cnt[0], 3);
        chk("single_gap1", dv_hist[1], done_hist[0] + 2);
        chk("single_gap2", dv_hist[2], done_hist[1] + 2);
        chk("single_release", fall_hist[0], done_hist[2] + 1);

        // Grant lock: requester 1 arrives mid-message.
        clear_stats();
        for (int k = 0; k < 4; k++) begin
            push(0, 8'h10 + 8'(k), k == 3);
            expect_b(8'h10 + 8'(k), 0);
        end
        drive_req();
        wait_ack(0, 2, 200);
        push(1, 8'h20, 1);
        expect_b(8'h20, 1);
        drive_req();
        run_idle(500);
        chk("lock_rises", rise_n, 2);
        chk("lock_fall", fall_hist[0], done_hist[3] + 1);
        chk("lock_rise_at", rise_cyc, done_hist[3] + 2);
        chk("lock_rise_val", rise_val, 2'b10);
        m_last = 1;

        // Timeout revoke with requester 1 pending.
        clear_stats();
        push(0, 8'h55, 0);
        expect_b(8'h55, 0);
        drive_req();
        wait_ack(0, 1, 100);
        push(1, 8'h66, 1);
        expect_b(8'h66, 1);
        drive_req();
        run_idle(500);
        chk("to_ack0", ack_cnt[0], 1);
        chk("to_fall", fall_hist[0], done_hist[0] + 17);
        chk("to_next_grant", rise_val, 2'b10);
        chk("to_next_at", rise_cyc, done_hist[0] + 18);
        m_last = 1;

        // Busy hold-off on entry to LOAD.
        clear_stats();
        force_busy = 1'b1;
        uart_busy  = 1'b1;
        prev_busy  = 1'b1;
        push(0, 8'h77, 1);
        expect_b(8'h77, 0);
        drive_req();
        repeat (20) tick();
        chk("busy_no_dv", dv_cnt, 0);
        chk("busy_grant_held", grant, 2'b01);
        force_busy = 1'b0;
        uart_busy  = 1'b0;
        prev_busy  = 1'b0;
        r = cyc;
        tick();
        chk("busy_dv_after", uart_d_v, 1);
        chk("busy_dv_cycle", dv_hist[0], r + 1);
        run_idle(200);
        m_last = 0;

        // Reset while waiting on the first byte of a message.
        clear_stats();
        push(0, 8'h88, 0);
        push(0, 8'h99, 1);
        expect_b(8'h88, 0);
        drive_req();
        wait_ack(0, 1, 100);
        rst = 1'b1;
        rq[0].delete();
        drive_req();
        tick();
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_dv", uart_d_v, 0);
        chk("mid_rst_ack", req_ack, 0);
        chk("mid_rst_uart_d", uart_d, 8'h00);
        rst = 1'b0;
        m_last = N - 1;
        push(1, 8'hAA, 1);
        push(0, 8'hBB, 1);
        sched();
        drive_req();
        run_idle(500);
        chk("post_rst_acks1", ack_cnt[1], 1);

        // Randomized traffic with in-message gaps and varied UART time.
        gmax    = 5;
        rnd_dur = 1'b1;
        for (int round = 0; round < 8; round++) begin
            clear_stats();
            for (int i = 0; i < N; i++) begin
                nm = int'($urandom_range(3, 0));
                for (int m = 0; m < nm; m++) begin
                    len = int'($urandom_range(4, 1));
                    for (int k = 0; k < len; k++)
                        push(i, 8'($urandom), k == len - 1);
                end
            end
            sched();
            drive_req();
            run_idle(3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
